// File: rtl/alu_control.sv
// Multi-cycle control stage feeding a 16-bit signed ALU: IDLE/READ/EXEC/WB sequencer with an 8x16 register file.
// Build option: define ALU_CTRL_CLEAR_ALL_EN so that CLEAR zeros all eight registers instead of only rd.
module alu_control #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_param,
  input  logic [DATA_W-1:0] alu_s,
  output logic              done,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_ADD     = 3'b001,
    OP_ADDI    = 3'b010,
    OP_SUB     = 3'b011,
    OP_SUBI    = 3'b100,
    OP_MUL     = 3'b101,
    OP_CLEAR   = 3'b110,
    OP_DISPLAY = 3'b111
  } op_t;

  state_t            r_state;
  logic [15:0]       r_instr;
  logic              r_ready;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [2:0]        r_param;
  logic [DATA_W-1:0] r_result;
  logic              r_done;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_disp_valid;
  logic [DATA_W-1:0] r_rf [8];

  op_t               w_op;
  logic [2:0]        w_rd;
  logic [2:0]        w_rs1;
  logic [2:0]        w_rs2;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_a_next;
  logic [DATA_W-1:0] w_b_next;

  assign w_op       = op_t'(r_instr[15:13]);
  assign w_rd       = r_instr[12:10];
  assign w_rs1      = r_instr[9:7];
  assign w_rs2      = r_instr[6:4];
  assign w_imm_sext = {{(DATA_W-IMM_W){r_instr[IMM_W-1]}}, r_instr[IMM_W-1:0]};

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_a_next = '0;
    w_b_next = '0;
    unique case (w_op)
      OP_LOAD:                 w_b_next = w_imm_sext;
      OP_ADD, OP_SUB, OP_MUL: begin
        w_a_next = r_rf[w_rs1];
        w_b_next = r_rf[w_rs2];
      end
      OP_ADDI, OP_SUBI: begin
        w_a_next = r_rf[w_rs1];
        w_b_next = w_imm_sext;
      end
      OP_DISPLAY:              w_a_next = r_rf[w_rs1];
      default: ;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_instr      <= '0;
      r_ready      <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_param      <= '0;
      r_result     <= '0;
      r_done       <= 1'b0;
      r_disp_data  <= '0;
      r_disp_valid <= 1'b0;
      // NOTE: the register file is architecturally zero after reset, so it is flop-based and cleared here rather than a RAM.
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else begin
      r_done       <= 1'b0;
      r_disp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_ready <= 1'b0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_a     <= w_a_next;
          r_b     <= w_b_next;
          r_param <= w_op;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result <= alu_s;
          r_done   <= 1'b1;
          if (w_op == OP_DISPLAY) begin
            r_disp_data  <= alu_s;
            r_disp_valid <= 1'b1;
          end
          r_state <= S_WB;
        end
        S_WB: begin
          unique case (w_op)
            OP_LOAD:    r_rf[w_rd] <= r_b;
`ifdef ALU_CTRL_CLEAR_ALL_EN
            OP_CLEAR:   for (int i = 0; i < 8; i++) r_rf[i] <= '0;
`else
            OP_CLEAR:   r_rf[w_rd] <= '0;
`endif
            OP_DISPLAY: ;
            default:    r_rf[w_rd] <= r_result;
          endcase
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_param   = r_param;
  assign done        = r_done;
  assign disp_data   = r_disp_data;
  assign disp_valid  = r_disp_valid;

endmodule

// File: tb/tb_alu_control.sv
// Directed bench for alu_control with a behavioural 16-bit ALU on the alu_a/alu_b/alu_param -> alu_s path.
module tb_alu_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] alu_a, alu_b, alu_s;
  logic [2:0]  alu_param;
  logic        done;
  logic [15:0] disp_data;
  logic        disp_valid;

  int total = 0;
  int bad   = 0;
  logic [15:0] last_disp = '0;
  int disp_pulses = 0;
  int disp_k = 0;

  alu_control #(.DATA_W(16), .IMM_W(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_param   (alu_param),
    .alu_s       (alu_s),
    .done        (done),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid)
  );

  always #5 clk = ~clk;

  // Downstream ALU: LOAD passes B, DISPLAY passes A, CLEAR yields 0.
  always_comb begin
    alu_s = '0;
    case (alu_param)
      3'b000:         alu_s = alu_b;
      3'b001, 3'b010: alu_s = alu_a + alu_b;
      3'b011, 3'b100: alu_s = alu_a - alu_b;
      3'b101:         alu_s = alu_a * alu_b;
      3'b110:         alu_s = '0;
      default:        alu_s = alu_a;
    endcase
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [6:0] low);
    return {op, rd, rs1, low};
  endfunction

  // Issues one instruction and checks ready/done timing for the four cycles after the accept edge.
  task automatic exec(input logic [15:0] ins, input bit hold);
    int n;
    n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_wait: instr_ready=%b expected 1", instr_ready);
      return;
    end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
    disp_pulses = 0;
    disp_k = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) instr_valid = 1'b0;
      total++;
      if (instr_ready !== (k == 4)) begin
        bad++;
        $display("FAIL ready_T0+%0d (instr %h): got %b expected %b", k, ins, instr_ready, (k == 4));
      end
      total++;
      if (done !== (k == 3)) begin
        bad++;
        $display("FAIL done_T0+%0d (instr %h): got %b expected %b", k, ins, done, (k == 3));
      end
      if (disp_valid === 1'b1) begin
        disp_pulses++;
        disp_k = k;
        last_disp = disp_data;
      end
    end
  endtask

  task automatic read_reg(input logic [2:0] r, output logic [15:0] v);
    exec(enc(3'b111, 3'd0, r, 7'd0), 1'b0);
    v = last_disp;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    rst_n = 1'b0;
    #12;
    total++; if (instr_ready !== 1'b1)  begin bad++; $display("FAIL rst_ready: got %b expected 1", instr_ready); end
    total++; if (alu_a !== 16'h0)       begin bad++; $display("FAIL rst_alu_a: got %h expected 0000", alu_a); end
    total++; if (alu_b !== 16'h0)       begin bad++; $display("FAIL rst_alu_b: got %h expected 0000", alu_b); end
    total++; if (alu_param !== 3'b000)  begin bad++; $display("FAIL rst_param: got %b expected 000", alu_param); end
    total++; if (done !== 1'b0)         begin bad++; $display("FAIL rst_done: got %b expected 0", done); end
    total++; if (disp_data !== 16'h0)   begin bad++; $display("FAIL rst_disp_data: got %h expected 0000", disp_data); end
    total++; if (disp_valid !== 1'b0)   begin bad++; $display("FAIL rst_disp_valid: got %b expected 0", disp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_reg(3'd3, v);
    total++; if (disp_pulses != 1 || v !== 16'h0000) begin
      bad++; $display("FAIL rst_display_r3: pulses=%0d data=%h expected 1 pulse, 0000", disp_pulses, v);
    end
  endtask

  task automatic test_load_add;
    logic [15:0] v;
    exec(16'h0405, 1'b0);
    exec(16'h087D, 1'b0);
    exec(enc(3'b001, 3'd3, 3'd1, {3'd2, 4'd0}), 1'b0);
    read_reg(3'd1, v);
    total++; if (v !== 16'h0005) begin bad++; $display("FAIL load_r1: got %h expected 0005", v); end
    read_reg(3'd2, v);
    total++; if (v !== 16'hFFFD) begin bad++; $display("FAIL load_neg_r2: got %h expected fffd", v); end
    read_reg(3'd3, v);
    total++; if (v !== 16'h0002) begin bad++; $display("FAIL add_r3: got %h expected 0002", v); end
  endtask

  task automatic test_arith;
    logic [15:0] v;
    exec(enc(3'b100, 3'd1, 3'd1, 7'd7), 1'b0);
    read_reg(3'd1, v);
    total++; if (v !== 16'hFFFE) begin bad++; $display("FAIL subi_r1: got %h expected fffe", v); end
    exec(enc(3'b101, 3'd4, 3'd1, {3'd1, 4'd0}), 1'b0);
    read_reg(3'd4, v);
    total++; if (v !== 16'h0004) begin bad++; $display("FAIL mul_r4: got %h expected 0004", v); end
    exec(enc(3'b000, 3'd5, 3'd0, 7'h10), 1'b0);
    exec(enc(3'b101, 3'd5, 3'd5, {3'd5, 4'd0}), 1'b0);
    read_reg(3'd5, v);
    total++; if (v !== 16'h0100) begin bad++; $display("FAIL mul_r5_256: got %h expected 0100", v); end
    exec(enc(3'b101, 3'd5, 3'd5, {3'd5, 4'd0}), 1'b0);
    read_reg(3'd5, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL mul_trunc_r5: got %h expected 0000", v); end
  endtask

  task automatic test_clear;
    logic [15:0] v;
    logic [15:0] exp_r2;
`ifdef ALU_CTRL_CLEAR_ALL_EN
    exp_r2 = 16'h0000;
`else
    exp_r2 = 16'h0009;
`endif
    exec(enc(3'b000, 3'd1, 3'd0, 7'd9), 1'b0);
    exec(enc(3'b000, 3'd2, 3'd0, 7'd9), 1'b0);
    exec(enc(3'b110, 3'd1, 3'd0, 7'd0), 1'b0);
    read_reg(3'd1, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL clear_r1: got %h expected 0000", v); end
    read_reg(3'd2, v);
    total++; if (v !== exp_r2) begin bad++; $display("FAIL clear_r2: got %h expected %h", v, exp_r2); end
  endtask

  task automatic test_display;
    logic [15:0] v;
    exec(enc(3'b000, 3'd5, 3'd0, 7'h10), 1'b0);
    exec(enc(3'b101, 3'd5, 3'd5, {3'd5, 4'd0}), 1'b0);
    exec(enc(3'b000, 3'd2, 3'd0, 7'h12), 1'b0);
    exec(enc(3'b101, 3'd2, 3'd2, {3'd5, 4'd0}), 1'b0);
    exec(enc(3'b000, 3'd6, 3'd0, 7'h34), 1'b0);
    exec(enc(3'b001, 3'd2, 3'd2, {3'd6, 4'd0}), 1'b0);
    exec(enc(3'b111, 3'd0, 3'd2, 7'd0), 1'b0);
    total++; if (disp_pulses != 1) begin bad++; $display("FAIL disp_pulse_count: got %0d expected 1", disp_pulses); end
    total++; if (disp_k != 3) begin bad++; $display("FAIL disp_pulse_cycle: got T0+%0d expected T0+3", disp_k); end
    total++; if (last_disp !== 16'h1234) begin bad++; $display("FAIL disp_data: got %h expected 1234", last_disp); end
    repeat (3) @(negedge clk);
    total++; if (disp_data !== 16'h1234 || disp_valid !== 1'b0) begin
      bad++; $display("FAIL disp_hold: data=%h valid=%b expected 1234/0", disp_data, disp_valid);
    end
    read_reg(3'd6, v);
    total++; if (v !== 16'h0034) begin bad++; $display("FAIL disp_r6_kept: got %h expected 0034", v); end
    read_reg(3'd5, v);
    total++; if (v !== 16'h0100) begin bad++; $display("FAIL disp_r5_kept: got %h expected 0100", v); end
    read_reg(3'd2, v);
    total++; if (v !== 16'h1234) begin bad++; $display("FAIL disp_r2_kept: got %h expected 1234", v); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] v;
    exec(enc(3'b010, 3'd7, 3'd6, 7'h7F), 1'b1);
    exec(enc(3'b010, 3'd7, 3'd7, 7'h7F), 1'b0);
    read_reg(3'd7, v);
    total++; if (v !== 16'h0032) begin bad++; $display("FAIL addi_chain_r7: got %h expected 0032", v); end
  endtask

  task automatic test_abort;
    logic [15:0] v;
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    instr = enc(3'b001, 3'd6, 3'd2, {3'd5, 4'd0});
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b expected 1", instr_ready); end
    total++; if (alu_a !== 16'h0 || alu_param !== 3'b000) begin
      bad++; $display("FAIL abort_alu: a=%h param=%b expected 0000/000", alu_a, alu_param);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      if (done === 1'b1) done_seen++;
    end
    total++; if (done_seen != 0) begin bad++; $display("FAIL abort_done: pulses=%0d expected 0", done_seen); end
    read_reg(3'd6, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL abort_r6: got %h expected 0000", v); end
    read_reg(3'd2, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL abort_r2_reset: got %h expected 0000", v); end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_arith();
    test_clear();
    test_display();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
